// File: rtl/ahbl_master_if_if.sv
// ----------------------------------------------------------------------------
// ahbl_master_if_if
// Bundles the command/response stream and the AHB-Lite bus signals of the
// ahbl_master_if initiator.
//   modport master : the initiator (drives cmd_ready, rsp_*, H* address/data)
//   modport slave  : the other side (requester + interconnect/slave)
// Signals:
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_size/cmd_wdata : command stream
//   rsp_valid/rsp_rdata/rsp_err                               : response
//   HADDR/HTRANS/HSIZE/HWRITE/HBURST/HWDATA                   : bus outputs
//   HREADY/HRESP/HRDATA                                       : bus inputs
// ----------------------------------------------------------------------------
interface ahbl_master_if_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_size;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
        input  HREADY, HRESP, HRDATA,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output HADDR, HTRANS, HSIZE, HWRITE, HBURST, HWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
        output HREADY, HRESP, HRDATA,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  HADDR, HTRANS, HSIZE, HWRITE, HBURST, HWDATA
    );
endinterface

// File: rtl/ahbl_master_if.sv
// ----------------------------------------------------------------------------
// ahbl_master_if
// AHB-Lite initiator: turns a valid/ready command stream into single
// NONSEQ transfers, one outstanding at a time, and returns a one-cycle
// response pulse carrying read data and an error flag.
// Ports:
//   HCLK    : bus clock
//   HRESETn : synchronous active-low reset
//   bus     : ahbl_master_if_if.master (command, response and AHB-Lite signals)
// Optional feature macro: AHBL_MASTER_TIMEOUT_EN
//   When defined, a data phase stalled by HREADY=0 for TIMEOUT_CYCLES
//   consecutive cycles is abandoned with rsp_err=1, rsp_rdata=0.
//   When undefined, the data phase waits for HREADY indefinitely.
// ----------------------------------------------------------------------------
module ahbl_master_if #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    ahbl_master_if_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [2:0]  r_size;
    logic        r_write;
    logic        r_illegal;
    logic        r_err;
    logic        w_cmd_illegal;
    logic        w_tmo_hit;

    // Only byte, aligned half and aligned word transfers are legal.
    assign w_cmd_illegal = (bus.cmd_size > 3'd2) ||
                           ((bus.cmd_size == 3'd1) && bus.cmd_addr[0]) ||
                           ((bus.cmd_size == 3'd2) && (bus.cmd_addr[1:0] != 2'b00));

`ifdef AHBL_MASTER_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES < 256) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] r_tmo;
    // Counter holds the number of stalls already seen, so the stall that
    // would make it TIMEOUT_CYCLES ends the data phase.
    assign w_tmo_hit = !bus.HREADY && (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_ff @(posedge HCLK) begin
        if (!HRESETn) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // An illegal command still spends one cycle in ADDR (with HTRANS held
    // IDLE) so its response lands two cycles after the handshake.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.cmd_valid) w_next = S_ADDR;
            S_ADDR:  if (r_illegal)       w_next = S_RESP;
                     else if (bus.HREADY) w_next = S_DATA;
            S_DATA:  if (bus.HREADY || w_tmo_hit) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_size    <= '0;
            r_write   <= 1'b0;
            r_illegal <= 1'b0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
`ifdef AHBL_MASTER_TIMEOUT_EN
            r_tmo     <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_addr    <= bus.cmd_addr;
                        r_wdata   <= bus.cmd_wdata;
                        r_size    <= bus.cmd_size;
                        r_write   <= bus.cmd_write;
                        r_illegal <= w_cmd_illegal;
                    end
                end
                S_ADDR: begin
                    if (r_illegal) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end
`ifdef AHBL_MASTER_TIMEOUT_EN
                    else if (bus.HREADY) begin
                        r_tmo <= '0;
                    end
`endif
                end
                S_DATA: begin
                    // ERROR responses and writes both return zero data.
                    if (bus.HREADY) begin
                        r_err   <= bus.HRESP;
                        r_rdata <= (!r_write && !bus.HRESP) ? bus.HRDATA : 32'd0;
                    end
`ifdef AHBL_MASTER_TIMEOUT_EN
                    else if (w_tmo_hit) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.cmd_ready = (r_state == S_IDLE);
    assign bus.HTRANS    = ((r_state == S_ADDR) && !r_illegal) ? 2'b10 : 2'b00;
    assign bus.HADDR     = r_addr;
    assign bus.HSIZE     = r_size;
    assign bus.HWRITE    = r_write;
    assign bus.HBURST    = 3'b000;
    assign bus.HWDATA    = r_wdata;
    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;

endmodule
